decode_stage_v2: RTL and testbench
==================================

Name: decode_stage_v2

Overview:
- Parametrised successor ID stage for the MIPS pipeline: internal register file with write-first bypass, branch/jump resolution, link-register handling, and a registered ID/EX pipeline register with valid, bubble, flush and freeze control.
- Adds a halt-drain state machine, so the pipeline empties cleanly after the HALT word before the halted flag is raised.
- Sits between the IF/ID register and the EX stage. Control bits come from the external control unit as an opaque bus.

Parameters:
- NB_DATA, 32, datapath width.
- NB_ADDR, 5, register address width; register file depth is 2**NB_ADDR.
- NB_CTRL, 16, width of the control bus passed to EX.
- LINK_REG, 31, destination register for JAL.
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops the program.
- DRAIN_CYCLES, 3, bubble cycles issued after HALT before the halted flag rises (must be >= 1).

Ports:
- clk  in  1  clock
- i_rst  in  1  reset
- i_valid  in  1  i_instruction is a real instruction
- i_instruction  in  NB_DATA  instruction word from IF/ID
- i_pcounter4  in  NB_DATA  PC+4 of the instruction
- i_ctrl  in  NB_CTRL  control bits from the control unit
- i_reg_dst  in  1  1: destination is rd, 0: destination is rt
- i_we  in  1  writeback write enable
- i_wr_addr  in  NB_ADDR  writeback address
- i_wr_data  in  NB_DATA  writeback data
- i_stall  in  1  load-use hazard; insert a bubble
- i_flush  in  1  squash the ID/EX register
- i_halt  in  1  debug freeze; all state holds
- i_dbg_addr  in  NB_ADDR  debug read address
- o_dbg_data  out  NB_DATA  combinational debug read
- o_jump  out  1  combinational redirect request
- o_addr2jump  out  NB_DATA  combinational redirect target
- o_valid  out  1  ID/EX entry valid
- o_ctrl  out  NB_CTRL  registered control bits
- o_reg_DA  out  NB_DATA  registered operand A
- o_reg_DB  out  NB_DATA  registered operand B
- o_immediate  out  NB_DATA  registered extended immediate
- o_rs  out  NB_ADDR  registered rs
- o_rt  out  NB_ADDR  registered rt
- o_dst  out  NB_ADDR  registered resolved destination
- o_opcode  out  6  registered opcode
- o_shamt  out  5  registered shamt
- o_func  out  6  registered funct
- o_link  out  1  registered; entry is JAL/JALR
- o_draining  out  1  registered; FSM in DRAIN
- o_stop  out  1  registered; FSM in HALTED

Behaviour:
- Clock is `clk`; reset `i_rst` is synchronous and active-high.
- Reset: every registered output is 0, all registers are 0, FSM is RUN.
- Register file:
  - Register 0 always reads 0 and ignores writes.
  - A write with i_we=1 commits at the clock edge.
  - Same-cycle write/read of the same nonzero address returns i_wr_data (bypass). This applies to the rs, rt and debug ports.
  - Writes continue during stall, flush, freeze, DRAIN and HALTED.
- Immediate: zero-extended for opcodes 001100, 001101, 001110; sign-extended otherwise.
- Jump resolution is combinational. It is active only when i_valid=1, FSM=RUN, and i_stall, i_flush and i_halt are all 0. Operands are post-bypass.
  - BEQ (000100): taken if A==B; target = pc4 + (simm<<2).
  - BNE (000101): taken if A!=B; same target.
  - J (000010) and JAL (000011): target = {pc4[31:28], instr[25:0], 2'b00}.
  - R-type 000000 with funct 001000 (JR) or 001001 (JALR): target = A.
  - o_addr2jump = 0 when o_jump = 0.
- Link handling, for JAL and for JALR (R-type, funct 001001):
  - o_reg_DA <= pc4, o_reg_DB <= 4, o_link <= 1, o_rs <= 0.
  - o_dst is LINK_REG for JAL and rd for JALR.
- Destination otherwise: o_dst = i_reg_dst ? rd : rt.
- Register operands otherwise: o_reg_DA = regfile[rs], o_reg_DB = regfile[rt].
- ID/EX register update, in priority order each edge:
  1. i_rst: reset.
  2. i_halt: hold all.
  3. i_flush, i_stall, i_valid=0, or FSM≠RUN: bubble (o_valid <= 0, o_ctrl <= 0, o_link <= 0; other fields don't-care, implemented as 0).
  4. Otherwise: load the decoded instruction with o_valid <= 1.
- HALT detection: in RUN, a loadable instruction equal to HALT_WORD loads a bubble, not the HALT word, and moves the FSM to DRAIN.
- FSM, states RUN / DRAIN / HALTED:
  - RUN -> DRAIN on HALT as above; the counter is loaded with DRAIN_CYCLES-1.
  - DRAIN: o_draining=1. Each non-frozen cycle issues a bubble and decrements the counter. At counter 0 the FSM goes to HALTED.
  - HALTED: o_stop=1 and bubbles only. It is left only by reset.
  - i_halt freezes the FSM and the counter.
- Latency: one cycle from ID input to the ID/EX outputs; zero cycles for o_jump.

Test Plan:
- Write r5=0x0000_00AA at edge N, with ADD rs=5 presented in the same cycle -> o_reg_DA=0x0000_00AA one cycle later (bypass); write to r0 -> r0 still reads 0.
- BEQ r1=r2=7, imm=0xFFFF, pc4=0x100 -> o_jump=1 and o_addr2jump=0xFC in the same cycle. Repeat with r2=8 -> o_jump=0, o_addr2jump=0.
- JAL instr=0x0C00_0010, pc4=0x1000_0008 -> o_addr2jump=0x1000_0040. Next cycle: o_dst=31, o_reg_DA=0x1000_0008, o_reg_DB=4, o_link=1.
- i_stall=1 on a valid BNE that would be taken -> o_jump=0, o_valid=0, o_ctrl=0. i_halt=1 for 3 cycles -> all outputs hold their values.
- HALT_WORD with DRAIN_CYCLES=3 -> o_valid=0; o_draining=1 for exactly 3 cycles, then o_stop=1 permanently. A valid ADD presented during DRAIN is not loaded (o_valid stays 0).
- Assert i_rst for one edge while in DRAIN -> all outputs 0 and FSM in RUN; the next valid instruction loads normally.

Source files
------------

// File: rtl/decode_stage_v2_if.sv
// Decode-stage bus: IF/ID inputs, writeback port, hazard controls,
// debug read port, redirect outputs and the ID/EX register outputs.
interface decode_stage_v2_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_CTRL = 16
);
  logic               i_valid;
  logic [NB_DATA-1:0] i_instruction;
  logic [NB_DATA-1:0] i_pcounter4;
  logic [NB_CTRL-1:0] i_ctrl;
  logic               i_reg_dst;
  logic               i_we;
  logic [NB_ADDR-1:0] i_wr_addr;
  logic [NB_DATA-1:0] i_wr_data;
  logic               i_stall;
  logic               i_flush;
  logic               i_halt;
  logic [NB_ADDR-1:0] i_dbg_addr;
  logic [NB_DATA-1:0] o_dbg_data;
  logic               o_jump;
  logic [NB_DATA-1:0] o_addr2jump;
  logic               o_valid;
  logic [NB_CTRL-1:0] o_ctrl;
  logic [NB_DATA-1:0] o_reg_DA;
  logic [NB_DATA-1:0] o_reg_DB;
  logic [NB_DATA-1:0] o_immediate;
  logic [NB_ADDR-1:0] o_rs;
  logic [NB_ADDR-1:0] o_rt;
  logic [NB_ADDR-1:0] o_dst;
  logic [5:0]         o_opcode;
  logic [4:0]         o_shamt;
  logic [5:0]         o_func;
  logic               o_link;
  logic               o_draining;
  logic               o_stop;

  modport slave (
    input  i_valid, i_instruction, i_pcounter4, i_ctrl, i_reg_dst,
           i_we, i_wr_addr, i_wr_data, i_stall, i_flush, i_halt, i_dbg_addr,
    output o_dbg_data, o_jump, o_addr2jump, o_valid, o_ctrl, o_reg_DA,
           o_reg_DB, o_immediate, o_rs, o_rt, o_dst, o_opcode, o_shamt,
           o_func, o_link, o_draining, o_stop
  );

  modport master (
    output i_valid, i_instruction, i_pcounter4, i_ctrl, i_reg_dst,
           i_we, i_wr_addr, i_wr_data, i_stall, i_flush, i_halt, i_dbg_addr,
    input  o_dbg_data, o_jump, o_addr2jump, o_valid, o_ctrl, o_reg_DA,
           o_reg_DB, o_immediate, o_rs, o_rt, o_dst, o_opcode, o_shamt,
           o_func, o_link, o_draining, o_stop
  );
endinterface

// File: rtl/decode_stage_v2.sv
// MIPS ID stage: register file with write-first bypass, branch/jump
// resolution, link handling, ID/EX register and HALT drain FSM.
module decode_stage_v2 #(
  parameter int                 NB_DATA      = 32,
  parameter int                 NB_ADDR      = 5,
  parameter int                 NB_CTRL      = 16,
  parameter int                 LINK_REG     = 31,
  parameter logic [NB_DATA-1:0] HALT_WORD    = 32'hFFFFFFFF,
  parameter int                 DRAIN_CYCLES = 3
) (
  input logic               clk,
  input logic               i_rst,
  decode_stage_v2_if.slave  bus
);
  localparam int DEPTH = 2 ** NB_ADDR;
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  typedef struct packed {
    logic               valid;
    logic [NB_CTRL-1:0] ctrl;
    logic [NB_DATA-1:0] da;
    logic [NB_DATA-1:0] db;
    logic [NB_DATA-1:0] imm;
    logic [NB_ADDR-1:0] rs;
    logic [NB_ADDR-1:0] rt;
    logic [NB_ADDR-1:0] dst;
    logic [5:0]         opcode;
    logic [4:0]         shamt;
    logic [5:0]         func;
    logic               link;
  } idex_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  idex_t              idex_q, idex_d;
  logic [NB_DATA-1:0] rf_q [DEPTH];

  logic [NB_DATA-1:0] instr;
  logic [5:0]         opcode, funct;
  logic [NB_ADDR-1:0] rs, rt, rd;
  logic [NB_DATA-1:0] a_data, b_data, imm_ext, br_target, j_target;
  logic               is_beq, is_bne, is_j, is_jal, is_jr, is_jalr;
  logic               zext, jump_en, load_ok, is_halt_word;
  logic               jump;
  logic [NB_DATA-1:0] jump_addr;

  assign instr  = bus.i_instruction;
  assign opcode = instr[31:26];
  assign rs     = NB_ADDR'(instr[25:21]);
  assign rt     = NB_ADDR'(instr[20:16]);
  assign rd     = NB_ADDR'(instr[15:11]);
  assign funct  = instr[5:0];

  // Write-first reads: a same-cycle write to a nonzero address is forwarded.
  assign a_data = (rs == '0) ? '0 :
                  (bus.i_we && bus.i_wr_addr == rs) ? bus.i_wr_data : rf_q[rs];
  assign b_data = (rt == '0) ? '0 :
                  (bus.i_we && bus.i_wr_addr == rt) ? bus.i_wr_data : rf_q[rt];
  assign bus.o_dbg_data = (bus.i_dbg_addr == '0) ? '0 :
                  (bus.i_we && bus.i_wr_addr == bus.i_dbg_addr) ? bus.i_wr_data
                                                                : rf_q[bus.i_dbg_addr];

  assign zext    = (opcode == 6'b001100) || (opcode == 6'b001101) || (opcode == 6'b001110);
  assign imm_ext = zext ? {{(NB_DATA-16){1'b0}}, instr[15:0]}
                        : {{(NB_DATA-16){instr[15]}}, instr[15:0]};

  assign is_beq  = (opcode == 6'b000100);
  assign is_bne  = (opcode == 6'b000101);
  assign is_j    = (opcode == 6'b000010);
  assign is_jal  = (opcode == 6'b000011);
  assign is_jr   = (opcode == 6'b000000) && (funct == 6'b001000);
  assign is_jalr = (opcode == 6'b000000) && (funct == 6'b001001);

  assign br_target = bus.i_pcounter4 + (imm_ext << 2);
  assign j_target  = {bus.i_pcounter4[NB_DATA-1:28], instr[25:0], 2'b00};

  assign jump_en = bus.i_valid && (state_q == ST_RUN) &&
                   !bus.i_stall && !bus.i_flush && !bus.i_halt;
  assign load_ok = bus.i_valid && (state_q == ST_RUN) &&
                   !bus.i_stall && !bus.i_flush;
  assign is_halt_word = (instr == HALT_WORD);

  // Redirect request and target, resolved in the same cycle
  always_comb begin
    jump      = 1'b0;
    jump_addr = '0;
    if (jump_en) begin
      if ((is_beq && a_data == b_data) || (is_bne && a_data != b_data)) begin
        jump      = 1'b1;
        jump_addr = br_target;
      end else if (is_j || is_jal) begin
        jump      = 1'b1;
        jump_addr = j_target;
      end else if (is_jr || is_jalr) begin
        jump      = 1'b1;
        jump_addr = a_data;
      end
    end
  end

  assign bus.o_jump      = jump;
  assign bus.o_addr2jump = jump_addr;

  // Next ID/EX contents: a zeroed bubble unless a real, non-HALT instruction loads
  always_comb begin
    idex_d = '0;
    if (load_ok && !is_halt_word) begin
      idex_d.valid  = 1'b1;
      idex_d.ctrl   = bus.i_ctrl;
      idex_d.imm    = imm_ext;
      idex_d.rs     = rs;
      idex_d.rt     = rt;
      idex_d.opcode = opcode;
      idex_d.shamt  = instr[10:6];
      idex_d.func   = funct;
      if (is_jal || is_jalr) begin
        idex_d.da   = bus.i_pcounter4;
        idex_d.db   = NB_DATA'(32'd4);
        idex_d.link = 1'b1;
        idex_d.rs   = '0;
        idex_d.dst  = is_jal ? NB_ADDR'(LINK_REG) : rd;
      end else begin
        idex_d.da   = a_data;
        idex_d.db   = b_data;
        idex_d.dst  = bus.i_reg_dst ? rd : rt;
      end
    end
  end

  // Drain FSM: HALT enters DRAIN, counter runs down to HALTED
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (load_ok && is_halt_word) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) state_d = ST_HALTED;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_HALTED;
    endcase
  end

  // Register file writes, independent of pipeline control
  always_ff @(posedge clk) begin
    if (i_rst) begin
      rf_q <= '{default: '0};
    end else if (bus.i_we && bus.i_wr_addr != '0) begin
      rf_q[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  // ID/EX register and FSM state; debug freeze holds both
  always_ff @(posedge clk) begin
    if (i_rst) begin
      idex_q  <= '0;
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else if (!bus.i_halt) begin
      idex_q  <= idex_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_valid     = idex_q.valid;
  assign bus.o_ctrl      = idex_q.ctrl;
  assign bus.o_reg_DA    = idex_q.da;
  assign bus.o_reg_DB    = idex_q.db;
  assign bus.o_immediate = idex_q.imm;
  assign bus.o_rs        = idex_q.rs;
  assign bus.o_rt        = idex_q.rt;
  assign bus.o_dst       = idex_q.dst;
  assign bus.o_opcode    = idex_q.opcode;
  assign bus.o_shamt     = idex_q.shamt;
  assign bus.o_func      = idex_q.func;
  assign bus.o_link      = idex_q.link;
  assign bus.o_draining  = (state_q == ST_DRAIN);
  assign bus.o_stop      = (state_q == ST_HALTED);
endmodule

// File: tb/tb_decode_stage_v2.sv
// Self-checking bench for decode_stage_v2: reference model plus scoreboard.
module tb_decode_stage_v2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_v2_if #(.NB_DATA(32), .NB_ADDR(5), .NB_CTRL(16)) bus ();

  decode_stage_v2 #(
    .NB_DATA(32), .NB_ADDR(5), .NB_CTRL(16), .LINK_REG(31),
    .HALT_WORD(32'hFFFFFFFF), .DRAIN_CYCLES(3)
  ) dut (
    .clk   (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic        valid;
    logic [15:0] ctrl;
    logic [31:0] da;
    logic [31:0] db;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [5:0]  op;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic        link;
    logic        drn;
    logic        stp;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_rf [32];
  int          m_state;   // 0 RUN, 1 DRAIN, 2 HALTED
  int          m_cnt;
  exp_t        m_last;
  exp_t        sb [$];
  logic        jump_smp;
  logic [31:0] addr_smp;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (bus.i_we && bus.i_wr_addr == a) return bus.i_wr_data;
    return m_rf[a];
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, s, t, d, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  task automatic idle();
    bus.i_valid = 1'b0; bus.i_instruction = '0; bus.i_pcounter4 = '0;
    bus.i_ctrl = '0; bus.i_reg_dst = 1'b0; bus.i_we = 1'b0;
    bus.i_wr_addr = '0; bus.i_wr_data = '0; bus.i_stall = 1'b0;
    bus.i_flush = 1'b0; bus.i_halt = 1'b0;
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] pc4,
                         input logic [15:0] ctrl, input logic rd_sel);
    bus.i_valid = 1'b1; bus.i_instruction = ins; bus.i_pcounter4 = pc4;
    bus.i_ctrl = ctrl; bus.i_reg_dst = rd_sel;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.i_we = 1'b1; bus.i_wr_addr = a; bus.i_wr_data = d;
  endtask

  // One clock: check combinational outputs, predict and queue the ID/EX entry,
  // advance the model, clock, then pop and compare the registered outputs.
  task automatic step();
    logic [31:0] ins, a, b, imm, exp_addr;
    logic [5:0]  op, fn;
    logic        exp_jump, active, loadable;
    exp_t        e, g;
    #1;
    ins = bus.i_instruction;
    op  = ins[31:26];
    fn  = ins[5:0];
    a   = m_read(ins[25:21]);
    b   = m_read(ins[20:16]);
    imm = (op == 6'h0C || op == 6'h0D || op == 6'h0E) ? {16'h0, ins[15:0]}
                                                       : {{16{ins[15]}}, ins[15:0]};
    loadable = bus.i_valid && m_state == 0 && !bus.i_stall && !bus.i_flush;
    active   = loadable && !bus.i_halt;
    exp_jump = 1'b0;
    exp_addr = 32'h0;
    if (active) begin
      if ((op == 6'd4 && a == b) || (op == 6'd5 && a != b)) begin
        exp_jump = 1'b1; exp_addr = bus.i_pcounter4 + {imm[29:0], 2'b00};
      end else if (op == 6'd2 || op == 6'd3) begin
        exp_jump = 1'b1; exp_addr = {bus.i_pcounter4[31:28], ins[25:0], 2'b00};
      end else if (op == 6'd0 && (fn == 6'd8 || fn == 6'd9)) begin
        exp_jump = 1'b1; exp_addr = a;
      end
    end
    jump_smp = bus.o_jump;
    addr_smp = bus.o_addr2jump;
    check_eq("o_jump", jump_smp, exp_jump);
    check_eq("o_addr2jump", addr_smp, exp_addr);
    check_eq("o_dbg_data", bus.o_dbg_data, m_read(bus.i_dbg_addr));

    e = '0;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_state = 0; m_cnt = 0;
    end else if (bus.i_halt) begin
      e = m_last;
    end else begin
      if (loadable && ins != 32'hFFFFFFFF) begin
        e.valid = 1'b1; e.ctrl = bus.i_ctrl; e.imm = imm;
        e.rs = ins[25:21]; e.rt = ins[20:16]; e.op = op; e.sh = ins[10:6]; e.fn = fn;
        if (op == 6'd3 || (op == 6'd0 && fn == 6'd9)) begin
          e.da = bus.i_pcounter4; e.db = 32'd4; e.link = 1'b1; e.rs = 5'd0;
          e.dst = (op == 6'd3) ? 5'd31 : ins[15:11];
        end else begin
          e.da = a; e.db = b;
          e.dst = bus.i_reg_dst ? ins[15:11] : ins[20:16];
        end
      end
      if (m_state == 0 && loadable && ins == 32'hFFFFFFFF) begin
        m_state = 1; m_cnt = 2;
      end else if (m_state == 1) begin
        if (m_cnt == 0) m_state = 2;
        else m_cnt--;
      end
      e.drn = (m_state == 1);
      e.stp = (m_state == 2);
    end
    if (!rst && bus.i_we && bus.i_wr_addr != 5'd0) m_rf[bus.i_wr_addr] = bus.i_wr_data;
    m_last = e;
    sb.push_back(e);

    @(posedge clk);
    #1;
    g = sb.pop_front();
    check_eq("o_valid", bus.o_valid, g.valid);
    check_eq("o_ctrl", bus.o_ctrl, g.ctrl);
    check_eq("o_reg_DA", bus.o_reg_DA, g.da);
    check_eq("o_reg_DB", bus.o_reg_DB, g.db);
    check_eq("o_immediate", bus.o_immediate, g.imm);
    check_eq("o_rs", bus.o_rs, g.rs);
    check_eq("o_rt", bus.o_rt, g.rt);
    check_eq("o_dst", bus.o_dst, g.dst);
    check_eq("o_opcode", bus.o_opcode, g.op);
    check_eq("o_shamt", bus.o_shamt, g.sh);
    check_eq("o_func", bus.o_func, g.fn);
    check_eq("o_link", bus.o_link, g.link);
    check_eq("o_draining", bus.o_draining, g.drn);
    check_eq("o_stop", bus.o_stop, g.stp);
  endtask

  initial begin
    int   ndrain;
    logic vld_seen;
    rst = 1'b1;
    idle();
    bus.i_dbg_addr = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_state = 0; m_cnt = 0; m_last = '0;

    step(); step();
    check_eq("reset_valid", bus.o_valid, 0);
    check_eq("reset_DA", bus.o_reg_DA, 0);
    rst = 1'b0;

    idle(); wr(1, 32'd7); step();
    idle(); wr(2, 32'd7); step();

    // Bypass: write r5 and read it as rs in the same cycle
    idle(); wr(5, 32'hAA); present(rtype(5, 1, 3, 0, 6'h20), 32'h40, 16'h1234, 1'b1); step();
    check_eq("bypass_DA", bus.o_reg_DA, 32'hAA);
    check_eq("bypass_DB", bus.o_reg_DB, 32'd7);
    check_eq("bypass_dst", bus.o_dst, 5'd3);

    // r0 ignores writes
    idle(); wr(0, 32'h55); bus.i_dbg_addr = 5'd0; step();
    check_eq("r0_read", bus.o_dbg_data, 0);
    idle(); bus.i_dbg_addr = 5'd5; step();
    check_eq("dbg_r5", bus.o_dbg_data, 32'hAA);

    // BEQ taken, then not taken
    idle(); present(itype(6'd4, 1, 2, 16'hFFFF), 32'h100, 16'h0001, 1'b0); step();
    check_eq("beq_taken", jump_smp, 1);
    check_eq("beq_target", addr_smp, 32'hFC);
    idle(); wr(2, 32'd8); step();
    idle(); present(itype(6'd4, 1, 2, 16'hFFFF), 32'h100, 16'h0001, 1'b0); step();
    check_eq("beq_not_taken", jump_smp, 0);
    check_eq("beq_nt_addr", addr_smp, 0);

    // JAL and JALR link handling
    idle(); present(32'h0C00_0010, 32'h1000_0008, 16'h0002, 1'b0); step();
    check_eq("jal_target", addr_smp, 32'h1000_0040);
    check_eq("jal_dst", bus.o_dst, 5'd31);
    check_eq("jal_DA", bus.o_reg_DA, 32'h1000_0008);
    check_eq("jal_DB", bus.o_reg_DB, 32'd4);
    check_eq("jal_link", bus.o_link, 1);
    idle(); present(rtype(1, 0, 4, 0, 6'h09), 32'h200, 16'h0003, 1'b1); step();
    check_eq("jalr_target", addr_smp, 32'd7);
    check_eq("jalr_dst", bus.o_dst, 5'd4);

    // Immediate extension
    idle(); present(itype(6'h0D, 1, 6, 16'h8001), 32'h210, 16'h0004, 1'b0); step();
    check_eq("ori_zext", bus.o_immediate, 32'h0000_8001);
    idle(); present(itype(6'h08, 1, 6, 16'h8001), 32'h214, 16'h0005, 1'b0); step();
    check_eq("addi_sext", bus.o_immediate, 32'hFFFF_8001);

    // Stall on a BNE that would be taken
    idle(); present(itype(6'd5, 1, 2, 16'h0004), 32'h300, 16'hABCD, 1'b0); bus.i_stall = 1'b1; step();
    check_eq("stall_jump", jump_smp, 0);
    check_eq("stall_valid", bus.o_valid, 0);
    check_eq("stall_ctrl", bus.o_ctrl, 0);

    // Freeze holds the ID/EX entry; writes still land
    idle(); present(rtype(1, 2, 7, 3, 6'h20), 32'h400, 16'h5A5A, 1'b1); step();
    for (int k = 0; k < 3; k++) begin
      idle(); present(rtype(2, 1, 9, 0, 6'h22), 32'h500, 16'h00FF, 1'b1);
      if (k == 0) wr(10, 32'h1234);
      bus.i_halt = 1'b1; step();
    end
    check_eq("freeze_valid", bus.o_valid, 1);
    check_eq("freeze_ctrl", bus.o_ctrl, 16'h5A5A);
    check_eq("freeze_DB", bus.o_reg_DB, 32'd8);

    // Flush squashes
    idle(); present(rtype(1, 2, 7, 3, 6'h20), 32'h400, 16'h5A5A, 1'b1); bus.i_flush = 1'b1; step();
    check_eq("flush_valid", bus.o_valid, 0);

    // HALT word and drain
    idle(); present(32'hFFFF_FFFF, 32'h600, 16'h7777, 1'b0); step();
    check_eq("halt_bubble", bus.o_valid, 0);
    ndrain = bus.o_draining ? 1 : 0;
    vld_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      idle(); present(rtype(1, 2, 11, 0, 6'h20), 32'h604, 16'h0101, 1'b1);
      bus.i_dbg_addr = 5'd10; step();
      if (bus.o_draining) ndrain++;
      vld_seen |= bus.o_valid;
    end
    check_eq("drain_cycles", ndrain, 3);
    check_eq("halted_stop", bus.o_stop, 1);
    check_eq("drain_no_load", vld_seen, 0);
    check_eq("dbg_r10", bus.o_dbg_data, 32'h1234);

    // Reset out of HALTED, re-enter DRAIN, freeze, then reset in DRAIN
    rst = 1'b1; idle(); step(); rst = 1'b0;
    idle(); present(32'hFFFF_FFFF, 32'h700, 16'h7777, 1'b0); step();
    idle(); present(rtype(1, 2, 11, 0, 6'h20), 32'h704, 16'h0101, 1'b1); bus.i_halt = 1'b1; step();
    idle(); step();
    check_eq("drain_before_rst", bus.o_draining, 1);
    idle(); rst = 1'b1; step();
    check_eq("rst_drain", bus.o_draining, 0);
    check_eq("rst_stop", bus.o_stop, 0);
    check_eq("rst_valid", bus.o_valid, 0);
    rst = 1'b0;
    idle(); wr(3, 32'h33); present(rtype(3, 0, 12, 0, 6'h20), 32'h800, 16'h0F0F, 1'b1); step();
    check_eq("post_rst_valid", bus.o_valid, 1);
    check_eq("post_rst_DA", bus.o_reg_DA, 32'h33);
    idle(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
